// File: rtl/sweep_scheduler_if.sv
// rtl/sweep_scheduler_if.sv - requester/scheduler bundle for the sweep scheduler
interface sweep_scheduler_if #(
    parameter int WIDTH = 4,
    parameter int PW    = 4
);
    logic [1:0]       req;
    logic [WIDTH-1:0] lo0;
    logic [WIDTH-1:0] hi0;
    logic [WIDTH-1:0] lo1;
    logic [WIDTH-1:0] hi1;
    logic [PW-1:0]    passes0;
    logic [PW-1:0]    passes1;
    logic [1:0]       gnt;
    logic             busy;
    logic [WIDTH-1:0] count;
    logic             dir;
    logic             done;
    logic             err;
    logic             abort;

    modport master (
        output req, lo0, hi0, lo1, hi1, passes0, passes1,
        input  gnt, busy, count, dir, done, err, abort
    );

    modport slave (
        input  req, lo0, hi0, lo1, hi1, passes0, passes1,
        output gnt, busy, count, dir, done, err, abort
    );
endinterface

// File: rtl/sweep_scheduler.sv
// rtl/sweep_scheduler.sv - round-robin bounded bounce-sweep scheduler; SWEEP_ABORT_EN enables req-drop abort
module sweep_scheduler #(
    parameter int WIDTH = 4,
    parameter int PW    = 4
) (
    input  logic               clk,
    input  logic               reset,
    sweep_scheduler_if.slave   bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DONE,
        S_ERR
`ifdef SWEEP_ABORT_EN
        , S_ABORT
`endif
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [PW-1:0]    passes_left_q, passes_left_d;
    logic             dir_q, dir_d;
    logic             sel_q, sel_d;
    logic             last_q, last_d;
    logic [1:0]       gnt_q, gnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
`ifdef SWEEP_ABORT_EN
    logic             abort_q, abort_d;
`endif

    logic             pick;
    logic [WIDTH-1:0] pick_lo;
    logic [WIDTH-1:0] pick_hi;
    logic [PW-1:0]    pick_passes;
    logic [WIDTH-1:0] target;

    // Round-robin winner: on contention favour the requester not served last.
    assign pick        = (bus.req == 2'b11) ? ~last_q : bus.req[1];
    assign pick_lo     = pick ? bus.lo1 : bus.lo0;
    assign pick_hi     = pick ? bus.hi1 : bus.hi0;
    assign pick_passes = pick ? bus.passes1 : bus.passes0;
    assign target      = dir_q ? lo_q : hi_q;

    // Next-state and registered-output computation.
    always_comb begin
        state_d       = state_q;
        count_d       = count_q;
        lo_d          = lo_q;
        hi_d          = hi_q;
        passes_left_d = passes_left_q;
        dir_d         = dir_q;
        sel_d         = sel_q;
        last_d        = last_q;
        gnt_d         = gnt_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        err_d         = 1'b0;
`ifdef SWEEP_ABORT_EN
        abort_d       = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.req != 2'b00) begin
                    sel_d         = pick;
                    lo_d          = pick_lo;
                    hi_d          = pick_hi;
                    passes_left_d = pick_passes;
                    gnt_d         = pick ? 2'b10 : 2'b01;
                    busy_d        = 1'b1;
                    if ((pick_lo > pick_hi) || (pick_passes == '0)) begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                    end else begin
                        state_d = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
`ifdef SWEEP_ABORT_EN
                if (!bus.req[sel_q]) begin
                    state_d = S_ABORT;
                    abort_d = 1'b1;
                end else
`endif
                begin
                    count_d = lo_q;
                    dir_d   = 1'b0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
`ifdef SWEEP_ABORT_EN
                if (!bus.req[sel_q]) begin
                    state_d = S_ABORT;
                    abort_d = 1'b1;
                end else
`endif
                if (count_q != target) begin
                    count_d = dir_q ? (count_q - WIDTH'(1)) : (count_q + WIDTH'(1));
                end else if (passes_left_q == PW'(1)) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    // Reverse at the bound and keep moving so the bound is not dwelt on.
                    passes_left_d = passes_left_q - PW'(1);
                    dir_d         = ~dir_q;
                    if (lo_q != hi_q) begin
                        count_d = dir_q ? (count_q + WIDTH'(1)) : (count_q - WIDTH'(1));
                    end
                end
            end
            default: begin
                // DONE, ERR and ABORT all release the grant and advance the pointer.
                state_d = S_IDLE;
                gnt_d   = 2'b00;
                busy_d  = 1'b0;
                last_d  = sel_q;
            end
        endcase
    end

    // State and output registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            count_q       <= '0;
            lo_q          <= '0;
            hi_q          <= '0;
            passes_left_q <= '0;
            dir_q         <= 1'b0;
            sel_q         <= 1'b0;
            last_q        <= 1'b1;
            gnt_q         <= 2'b00;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
`ifdef SWEEP_ABORT_EN
            abort_q       <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            lo_q          <= lo_d;
            hi_q          <= hi_d;
            passes_left_q <= passes_left_d;
            dir_q         <= dir_d;
            sel_q         <= sel_d;
            last_q        <= last_d;
            gnt_q         <= gnt_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            err_q         <= err_d;
`ifdef SWEEP_ABORT_EN
            abort_q       <= abort_d;
`endif
        end
    end

    assign bus.gnt   = gnt_q;
    assign bus.busy  = busy_q;
    assign bus.count = count_q;
    assign bus.dir   = dir_q;
    assign bus.done  = done_q;
    assign bus.err   = err_q;
`ifdef SWEEP_ABORT_EN
    assign bus.abort = abort_q;
`else
    assign bus.abort = 1'b0;
`endif

endmodule

// File: tb/tb_sweep_scheduler.sv
// tb/tb_sweep_scheduler.sv - randomized self-checking bench for sweep_scheduler
module tb_sweep_scheduler;
    localparam int WIDTH = 4;
    localparam int PW    = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] req_v;
    logic [3:0] jlo [2];
    logic [3:0] jhi [2];
    logic [3:0] jp  [2];

    int checks = 0;
    int errors = 0;

    int         last_srv;
    logic [3:0] m_count;
    logic       m_dir;

    sweep_scheduler_if #(.WIDTH(WIDTH), .PW(PW)) bus ();

    sweep_scheduler #(.WIDTH(WIDTH), .PW(PW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    assign bus.req     = req_v;
    assign bus.lo0     = jlo[0];
    assign bus.hi0     = jhi[0];
    assign bus.lo1     = jlo[1];
    assign bus.hi1     = jhi[1];
    assign bus.passes0 = jp[0];
    assign bus.passes1 = jp[1];

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Position of a bounce sweep k cycles into RUN: triangle wave between lo and lo+d.
    function automatic int exp_count(input int lo, input int d, input int k);
        int m;
        if (d == 0) return lo;
        m = k % (2 * d);
        return (m <= d) ? lo + m : lo + 2 * d - m;
    endfunction

    // Direction register seen k cycles into RUN: it flips the cycle after each bound hit.
    function automatic int exp_dir(input int d, input int k);
        if (d == 0) return k % 2;
        if (k == 0) return 0;
        return ((k - 1) / d) % 2;
    endfunction

    task automatic set_job(input int r, input int lo, input int hi, input int p);
        jlo[r]   = 4'(lo);
        jhi[r]   = 4'(hi);
        jp[r]    = 4'(p);
        req_v[r] = 1'b1;
    endtask

    task automatic rand_job(input int r);
        int lo, hi, p;
        lo = $urandom_range(0, 15);
        hi = $urandom_range(lo, (lo + 5 > 15) ? 15 : lo + 5);
        p  = $urandom_range(1, 4);
        case ($urandom_range(0, 9))
            0: if (lo != 0) hi = $urandom_range(0, lo - 1); else p = 0;
            1: p = 0;
            2: begin lo = 0; hi = 15; end
            default: ;
        endcase
        set_job(r, lo, hi, p);
    endtask

    // Called at the negedge of an IDLE cycle with at least one req high; serves one job.
    task automatic serve_one();
        int w, lo, hi, p, d, len;
        w  = (req_v == 2'b11) ? 1 - last_srv : (req_v[1] ? 1 : 0);
        lo = int'(jlo[w]);
        hi = int'(jhi[w]);
        p  = int'(jp[w]);
        next_cycle();
        check("grant_gnt", 32'(bus.gnt), (w == 1) ? 2 : 1);
        check("grant_busy", 32'(bus.busy), 1);
        if (lo > hi || p == 0) begin
            check("err_pulse", 32'(bus.err), 1);
            check("err_count", 32'(bus.count), 32'(m_count));
            check("err_dir", 32'(bus.dir), 32'(m_dir));
            check("err_done", 32'(bus.done), 0);
            req_v[w] = 1'b0;
            next_cycle();
            check("err_gnt_drop", 32'(bus.gnt), 0);
            check("err_busy_drop", 32'(bus.busy), 0);
            check("err_clear", 32'(bus.err), 0);
            last_srv = w;
            return;
        end
        check("load_err", 32'(bus.err), 0);
        check("load_done", 32'(bus.done), 0);
        next_cycle();
        d   = hi - lo;
        len = (d > 0) ? p * d + 1 : p;
        for (int k = 0; k < len; k++) begin
            check("run_count", 32'(bus.count), exp_count(lo, d, k));
            check("run_dir", 32'(bus.dir), exp_dir(d, k));
            check("run_done", 32'(bus.done), 0);
            check("run_gnt", 32'(bus.gnt), (w == 1) ? 2 : 1);
            next_cycle();
        end
        check("done_pulse", 32'(bus.done), 1);
        check("done_count", 32'(bus.count), exp_count(lo, d, len - 1));
        check("done_dir", 32'(bus.dir), exp_dir(d, len - 1));
        check("done_gnt", 32'(bus.gnt), (w == 1) ? 2 : 1);
        check("done_abort", 32'(bus.abort), 0);
        req_v[w] = 1'b0;
        next_cycle();
        check("idle_gnt", 32'(bus.gnt), 0);
        check("idle_busy", 32'(bus.busy), 0);
        check("idle_done", 32'(bus.done), 0);
        m_count  = 4'(exp_count(lo, d, len - 1));
        m_dir    = exp_dir(d, len - 1) != 0;
        last_srv = w;
    endtask

    task automatic apply_reset(input int cycles);
        reset = 1'b1;
        req_v = 2'b00;
        repeat (cycles) next_cycle();
        reset    = 1'b0;
        last_srv = 1;
        m_count  = 4'd0;
        m_dir    = 1'b0;
    endtask

    initial begin
        int done_seen;
        req_v = 2'b00;
        for (int r = 0; r < 2; r++) begin
            jlo[r] = 4'd0;
            jhi[r] = 4'd0;
            jp[r]  = 4'd0;
        end
        reset = 1'b1;
        @(negedge clk);
        apply_reset(2);
        check("rst_count", 32'(bus.count), 0);
        check("rst_dir", 32'(bus.dir), 0);
        check("rst_gnt", 32'(bus.gnt), 0);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_done", 32'(bus.done), 0);
        check("rst_err", 32'(bus.err), 0);
        check("rst_abort", 32'(bus.abort), 0);

        // Basic bounce, then the two rejection cases, then a zero-span job.
        set_job(0, 2, 4, 2);
        serve_one();
        set_job(1, 5, 3, 2);
        serve_one();
        set_job(1, 1, 3, 0);
        serve_one();
        set_job(0, 7, 7, 3);
        serve_one();

        // Contention from reset: expect grants 0, 1, 0.
        apply_reset(2);
        set_job(0, 1, 3, 1);
        set_job(1, 4, 6, 2);
        serve_one();
        check("rr_second_pending", 32'(req_v), 2);
        serve_one();
        set_job(0, 3, 5, 1);
        set_job(1, 0, 2, 1);
        serve_one();
        serve_one();

        // Full-range sweep with no wrap.
        set_job(0, 0, 15, 3);
        serve_one();

        // Reset in the middle of a full-range sweep discards the job silently.
        set_job(0, 0, 15, 3);
        next_cycle();
        next_cycle();
        repeat (10) next_cycle();
        reset = 1'b1;
        next_cycle();
        check("midrst_count", 32'(bus.count), 0);
        check("midrst_dir", 32'(bus.dir), 0);
        check("midrst_gnt", 32'(bus.gnt), 0);
        check("midrst_busy", 32'(bus.busy), 0);
        check("midrst_done", 32'(bus.done), 0);
        reset    = 1'b0;
        req_v    = 2'b00;
        last_srv = 1;
        m_count  = 4'd0;
        m_dir    = 1'b0;
        done_seen = 0;
        repeat (40) begin
            next_cycle();
            if (bus.done) done_seen++;
        end
        check("midrst_no_done", 32'(done_seen), 0);
        check("midrst_idle_count", 32'(bus.count), 0);

`ifdef SWEEP_ABORT_EN
        set_job(0, 0, 15, 3);
        next_cycle();
        next_cycle();
        repeat (5) next_cycle();
        req_v[0] = 1'b0;
        next_cycle();
        check("abort_pulse", 32'(bus.abort), 1);
        check("abort_gnt", 32'(bus.gnt), 1);
        check("abort_count", 32'(bus.count), 5);
        check("abort_done", 32'(bus.done), 0);
        next_cycle();
        check("abort_release", 32'(bus.gnt), 0);
        check("abort_clear", 32'(bus.abort), 0);
        check("abort_no_done", 32'(bus.done), 0);
        m_count  = 4'd5;
        m_dir    = 1'b0;
        last_srv = 0;
`endif

        // Randomized traffic against the sweep model.
        for (int it = 0; it < 150; it++) begin
            if (req_v == 2'b00) begin
                int mask;
                mask = $urandom_range(1, 3);
                if (mask[0]) rand_job(0);
                if (mask[1]) rand_job(1);
            end else if ($urandom_range(0, 1) == 1) begin
                rand_job(req_v[0] ? 1 : 0);
            end
            serve_one();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
